// File: rtl/pc_redirect_pkg.sv
// pc_redirect_pkg: shared pipeline constants and opcode encodings for the
// fetch-side PC redirect unit.
//   PKG_RESET_PC  - default fetch address after reset
//   PKG_RAS_DEPTH - default return-address-stack depth
//   opcode_e      - decode-stage opcode encodings
package pc_redirect_pkg;

    localparam logic [15:0] PKG_RESET_PC  = 16'h0000;
    localparam int unsigned PKG_RAS_DEPTH = 8;

    typedef enum logic [3:0] {
        OP_NOP  = 4'h0,
        OP_BEQ  = 4'h1,
        OP_BNE  = 4'h2,
        OP_JMP  = 4'h3,
        OP_CALL = 4'h4,
        OP_RET  = 4'h5,
        OP_FOR  = 4'h6
    } opcode_e;

endpackage

// File: rtl/pc_redirect_return_stack.sv
// return_stack: circular return-address stack.
//   clk, rst_n    - clock, asynchronous active-low reset
//   push, pop     - one operation per cycle (push wins if both)
//   push_data     - address to push
//   top_data      - current top entry (0 when empty)
//   empty, full   - occupancy flags
//   overflow      - sticky: push while full (oldest entry overwritten)
//   underflow     - registered one-cycle pulse: pop while empty
module return_stack #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] top_data,
    output logic             empty,
    output logic             full,
    output logic             overflow,
    output logic             underflow
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    ptr;      // next free slot; top entry sits at ptr-1
    logic [CW-1:0]    count;
    logic [PW-1:0]    top_idx;

    assign top_idx  = ptr - PW'(1);
    assign empty    = (count == '0);
    assign full     = (count == CW'(DEPTH));
    assign top_data = empty ? '0 : mem[top_idx];

    // Entry contents need no reset; only pointer and count define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr       <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            underflow <= 1'b0;
            if (push) begin
                // When full, advancing ptr lands on the oldest slot, so the
                // write above overwrites it and count saturates.
                ptr <= ptr + PW'(1);
                if (full) begin
                    overflow <= 1'b1;
                end else begin
                    count <= count + CW'(1);
                end
            end else if (pop) begin
                if (empty) begin
                    underflow <= 1'b1;
                end else begin
                    ptr   <= ptr - PW'(1);
                    count <= count - CW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/pc_redirect.sv
// pc_redirect: fetch PC register and next-PC mux driven by decode-stage kill.
//   clk, rst_n        - clock, asynchronous active-low reset
//   stall             - hold PC, ignore kill
//   kill              - redirect request from decode
//   id_op, id_pc      - opcode and PC of the instruction in decode
//   id_target         - computed branch/jump/call target
//   pc                - registered fetch address
//   flush_ifid        - combinational bubble strobe into IF/ID
//   ras_empty         - return stack holds no entries
//   ras_overflow      - sticky push-while-full flag
//   ras_underflow     - one-cycle pulse after RET while empty
module pc_redirect
    import pc_redirect_pkg::*;
#(
    parameter logic [15:0] RESET_PC  = PKG_RESET_PC,
    parameter int unsigned RAS_DEPTH = PKG_RAS_DEPTH
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        kill,
    input  logic [3:0]  id_op,
    input  logic [15:0] id_pc,
    input  logic [15:0] id_target,
    output logic [15:0] pc,
    output logic        flush_ifid,
    output logic        ras_empty,
    output logic        ras_overflow,
    output logic        ras_underflow
);

    opcode_e     op;
    logic        redirect;
    logic        do_call;
    logic        do_ret;
    logic [15:0] ras_top;
    logic [15:0] ret_addr;
    logic [15:0] next_pc;
    logic        ras_full;

    assign op = opcode_e'(id_op);

    // Gating with rst_n keeps flush low and blocks RAS writes during reset.
    assign redirect   = kill & ~stall & rst_n;
    assign flush_ifid = redirect;
    assign do_call    = redirect & (op == OP_CALL);
    assign do_ret     = redirect & (op == OP_RET);
    assign ret_addr   = id_pc + 16'd1;

    always_comb begin
        next_pc = pc + 16'd1;
        if (stall) begin
            next_pc = pc;
        end else if (redirect) begin
            next_pc = (op == OP_RET) ? ras_top : id_target;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else begin
            pc <= next_pc;
        end
    end

    return_stack #(
        .DEPTH (RAS_DEPTH),
        .WIDTH (16)
    ) u_ras (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (do_call),
        .pop       (do_ret),
        .push_data (ret_addr),
        .top_data  (ras_top),
        .empty     (ras_empty),
        .full      (ras_full),
        .overflow  (ras_overflow),
        .underflow (ras_underflow)
    );

endmodule

// File: tb/tb_pc_redirect.sv
module tb_pc_redirect;
    import pc_redirect_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        kill;
    logic [3:0]  id_op;
    logic [15:0] id_pc;
    logic [15:0] id_target;
    logic [15:0] pc;
    logic        flush_ifid;
    logic        ras_empty;
    logic        ras_overflow;
    logic        ras_underflow;

    typedef struct {
        string       name;
        logic [15:0] pc;
        logic        flush;
        logic        empty;
        logic        ovf;
        logic        unf;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    pc_redirect #(
        .RESET_PC  (16'h0000),
        .RAS_DEPTH (8)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall         (stall),
        .kill          (kill),
        .id_op         (id_op),
        .id_pc         (id_pc),
        .id_target     (id_target),
        .pc            (pc),
        .flush_ifid    (flush_ifid),
        .ras_empty     (ras_empty),
        .ras_overflow  (ras_overflow),
        .ras_underflow (ras_underflow)
    );

    always #5 clk = ~clk;

    // Monitor: one expectation per cycle, checked mid-cycle on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                exp_t e;
                e = q.pop_front();
                total++;
                if ({pc, flush_ifid, ras_empty, ras_overflow, ras_underflow} !==
                    {e.pc, e.flush, e.empty, e.ovf, e.unf}) begin
                    bad++;
                    $display("FAIL %s: got pc=%h flush=%b empty=%b ovf=%b unf=%b, want pc=%h flush=%b empty=%b ovf=%b unf=%b",
                             e.name, pc, flush_ifid, ras_empty, ras_overflow, ras_underflow,
                             e.pc, e.flush, e.empty, e.ovf, e.unf);
                end
            end
        end
    end

    // Called just after a rising edge: drive inputs, queue the expected
    // mid-cycle view (pc from the last edge, flush from these inputs), wait one cycle.
    task automatic step(input string nm, input logic st, input logic kl,
                        input logic [3:0] op, input logic [15:0] ipc, input logic [15:0] tgt,
                        input logic [15:0] epc, input logic ef, input logic ee,
                        input logic eo, input logic eu);
        exp_t e;
        #1;
        stall = st; kill = kl; id_op = op; id_pc = ipc; id_target = tgt;
        e.name = nm; e.pc = epc; e.flush = ef; e.empty = ee; e.ovf = eo; e.unf = eu;
        q.push_back(e);
        @(posedge clk);
    endtask

    initial begin
        rst_n = 1'b0; stall = 1'b0; kill = 1'b0;
        id_op = OP_NOP; id_pc = '0; id_target = '0;
        @(posedge clk);
        // Reset held with kill high: flush must stay low.
        step("in_reset", 0, 1, OP_JMP, 16'h0000, 16'h0040, 16'h0000, 0, 1, 0, 0);
        #1 rst_n = 1'b1;

        step("seq0", 0, 0, OP_NOP, 16'h0, 16'h0, 16'h0000, 0, 1, 0, 0);
        step("seq1", 0, 0, OP_NOP, 16'h0, 16'h0, 16'h0001, 0, 1, 0, 0);
        step("seq2", 0, 0, OP_NOP, 16'h0, 16'h0, 16'h0002, 0, 1, 0, 0);
        step("seq3", 0, 0, OP_NOP, 16'h0, 16'h0, 16'h0003, 0, 1, 0, 0);
        step("seq4", 0, 0, OP_NOP, 16'h0, 16'h0, 16'h0004, 0, 1, 0, 0);
        step("jmp_kill", 0, 1, OP_JMP, 16'h0004, 16'h0040, 16'h0005, 1, 1, 0, 0);
        step("jmp_tgt", 0, 0, OP_NOP, 16'h0, 16'h0, 16'h0040, 0, 1, 0, 0);
        step("jmp_next", 0, 0, OP_NOP, 16'h0, 16'h0, 16'h0041, 0, 1, 0, 0);

        step("call", 0, 1, OP_CALL, 16'h0010, 16'h0100, 16'h0042, 1, 1, 0, 0);
        step("call_tgt", 0, 0, OP_NOP, 16'h0, 16'h0, 16'h0100, 0, 0, 0, 0);
        step("stall_kill", 1, 1, OP_RET, 16'h0105, 16'h0, 16'h0101, 0, 0, 0, 0);
        step("ret_after_stall", 0, 1, OP_RET, 16'h0105, 16'h0, 16'h0101, 1, 0, 0, 0);
        step("ret_tgt", 0, 0, OP_NOP, 16'h0, 16'h0, 16'h0011, 0, 1, 0, 0);
        step("stall_only", 1, 0, OP_NOP, 16'h0, 16'h0, 16'h0012, 0, 1, 0, 0);
        step("beq_kill", 0, 1, OP_BEQ, 16'h0011, 16'h0200, 16'h0012, 1, 1, 0, 0);
        step("other_op_kill", 0, 1, 4'hF, 16'h0200, 16'h0300, 16'h0200, 1, 1, 0, 0);
        step("other_op_tgt", 0, 0, OP_NOP, 16'h0, 16'h0, 16'h0300, 0, 1, 0, 0);

        // Nine calls into an 8-deep stack: the push of 1 gets overwritten.
        for (int i = 0; i < 9; i++) begin
            step("call_fill", 0, 1, OP_CALL, 16'(i), 16'h0500 + 16'(i),
                 (i == 0) ? 16'h0301 : 16'h0500 + 16'(i - 1), 1, (i == 0), 0, 0);
        end
        for (int j = 0; j < 8; j++) begin
            step("ret_drain", 0, 1, OP_RET, 16'h0, 16'h0,
                 (j == 0) ? 16'h0508 : 16'(10 - j), 1, 0, 1, 0);
        end
        step("ret_empty", 0, 1, OP_RET, 16'h0, 16'h0, 16'h0002, 1, 1, 1, 0);
        step("underflow_pulse", 0, 0, OP_NOP, 16'h0, 16'h0, 16'h0000, 0, 1, 1, 1);

        step("jmp_ffff", 0, 1, OP_JMP, 16'h0, 16'hFFFF, 16'h0001, 1, 1, 1, 0);
        step("at_ffff", 0, 0, OP_NOP, 16'h0, 16'h0, 16'hFFFF, 0, 1, 1, 0);
        step("call_ffff", 0, 1, OP_CALL, 16'hFFFF, 16'h0020, 16'h0000, 1, 1, 1, 0);
        step("ret_wrap", 0, 1, OP_RET, 16'h0, 16'h0, 16'h0020, 1, 0, 1, 0);
        step("call_pre_rst", 0, 1, OP_CALL, 16'h0030, 16'h0040, 16'h0000, 1, 1, 1, 0);

        // Reset dropped between edges while a redirect is on the inputs.
        begin
            exp_t e;
            #1;
            kill = 1'b1; id_op = OP_JMP; id_target = 16'h0077;
            #2 rst_n = 1'b0;
            e.name = "async_reset"; e.pc = 16'h0000; e.flush = 1'b0;
            e.empty = 1'b1; e.ovf = 1'b0; e.unf = 1'b0;
            q.push_back(e);
            @(posedge clk);
        end
        #1 rst_n = 1'b1;
        step("after_reset", 0, 0, OP_NOP, 16'h0, 16'h0, 16'h0000, 0, 1, 0, 0);
        step("after_reset1", 0, 0, OP_NOP, 16'h0, 16'h0, 16'h0001, 0, 1, 0, 0);

        begin
            int waited;
            waited = 0;
            while (q.size() > 0 && waited < 10) begin
                @(posedge clk);
                waited++;
            end
            if (q.size() > 0) begin
                total++;
                bad++;
                $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
            end
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
